// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//   Operand-fetch stage between instruction decode and the ALU of the
//   multi-cycle CPU. The stage accepts a decoded rs/rt/imm request, drives the
//   register-file read ports for one FETCH cycle, and latches the A/B operands
//   and the extended immediate. It then presents them downstream.
//   Register 0 always reads as zero.
//
//   Optional feature macro: OPF_BYPASS_EN
//     defined   : a write-back that lands on the FETCH edge to rs/rt (non-zero
//                 register) is forwarded into A/B instead of the stale read.
//     undefined : A/B take Data1/Data2 (pre-write value on a shared edge).
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     request handshake from decode
//   in_rs, in_rt, in_imm  source registers and raw immediate
//   in_sext               1 = sign-extend immediate, 0 = zero-extend
//   Read1/Read2           register-file read addresses (held between fetches)
//   Data1/Data2           combinational register-file read data
//   wb_en/wb_reg/wb_data  write-back port shared with the register file
//   out_valid/out_ready   operand handshake to the ALU stage
//   A, B, Imm             latched operands and extended immediate
// -----------------------------------------------------------------------------
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_sext,
  output logic [REG_AW-1:0] Read1,
  output logic [REG_AW-1:0] Read2,
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Imm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              accept_s;
  logic              in_ready_s;
  logic              out_valid_r;
  logic [REG_AW-1:0] rs_r;
  logic [REG_AW-1:0] rt_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] imm_r;
  logic [DATA_W-1:0] a_s;
  logic [DATA_W-1:0] b_s;

  // Widen the raw immediate; sign-extension replicates its top bit.
  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                input logic sext);
    ext_imm = {{(DATA_W-IMM_W){sext & imm[IMM_W-1]}}, imm};
  endfunction

  // Operand select: register 0 is forced to zero ahead of any forwarding.
  function automatic logic [DATA_W-1:0] sel_op(input logic [REG_AW-1:0] r,
                                               input logic [DATA_W-1:0] d,
                                               input logic              we,
                                               input logic [REG_AW-1:0] wr,
                                               input logic [DATA_W-1:0] wd);
    if (r == {REG_AW{1'b0}}) begin
      sel_op = {DATA_W{1'b0}};
    end else if (we && (wr == r)) begin
      sel_op = wd;
    end else begin
      sel_op = d;
    end
  endfunction

  // Ready never looks at in_valid, so decode can use it to form its own valid.
  assign in_ready_s = (state_r == IDLE) | ((state_r == VALID) & out_ready);
  assign accept_s   = in_valid & in_ready_s;
  assign in_ready   = in_ready_s;

`ifdef OPF_BYPASS_EN
  logic              byp_en_s;
  assign byp_en_s = wb_en;
`else
  // Write-back forwarding is compiled out; keep the ports visibly consumed.
  logic              byp_en_s;
  logic              unused_wb_s;
  assign byp_en_s    = 1'b0;
  assign unused_wb_s = ^{wb_en, wb_reg, wb_data};
`endif

  // Next-state logic and FETCH-cycle operand selection.
  always_comb begin
    state_s = state_r;
    a_s     = sel_op(rs_r, Data1, byp_en_s, wb_reg, wb_data);
    b_s     = sel_op(rt_r, Data2, byp_en_s, wb_reg, wb_data);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        state_s = VALID;
      end
      VALID: begin
        if (out_ready) begin
          if (in_valid) begin
            state_s = FETCH;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = VALID;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, request capture and operand registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      rs_r        <= {REG_AW{1'b0}};
      rt_r        <= {REG_AW{1'b0}};
      a_r         <= {DATA_W{1'b0}};
      b_r         <= {DATA_W{1'b0}};
      imm_r       <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s == VALID);
      if (accept_s) begin
        rs_r  <= in_rs;
        rt_r  <= in_rt;
        imm_r <= ext_imm(in_imm, in_sext);
      end
      // A/B only move at the end of FETCH; they stay frozen while VALID stalls.
      if (state_r == FETCH) begin
        a_r <= a_s;
        b_r <= b_s;
      end
    end
  end

  assign Read1     = rs_r;
  assign Read2     = rt_r;
  assign out_valid = out_valid_r;
  assign A         = a_r;
  assign B         = b_r;
  assign Imm       = imm_r;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//   Self-checking bench for operand_fetch with a behavioural register file.
//   Expected operands are queued when a request is accepted and compared when
//   the ALU-side handshake completes.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        sext;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm_x;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [15:0] in_imm;
  logic        in_sext;
  logic [4:0]  Read1;
  logic [4:0]  Read2;
  logic [31:0] Data1;
  logic [31:0] Data2;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Imm;

  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  int   cyc      = 0;
  int   last_hs  = 0;
  bit   have_last = 1'b0;
  bit   gap_chk   = 1'b0;
  int   hs_count  = 0;

  logic [31:0] rf [32];

  operand_fetch dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_sext(in_sext),
    .Read1(Read1), .Read2(Read2), .Data1(Data1), .Data2(Data2),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .Imm(Imm)
  );

  always #5 clock = ~clock;

  // Register file: write on the clock edge, combinational read.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (wb_en) rf[wb_reg] <= wb_data;
  end
  assign Data1 = rf[Read1];
  assign Data2 = rf[Read2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: compare every completed ALU-side handshake.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      vec_t e;
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("A", A, e.a);
        check("B", B, e.b);
        check("Imm", Imm, e.imm_x);
      end
      if (gap_chk && have_last) check("pulse_gap", cyc - last_hs, 32'd2);
      last_hs   = cyc;
      have_last = 1'b1;
      hs_count++;
    end
  end

  // Present one request; waited reports how many extra cycles it took.
  task automatic send(input vec_t v, output int waited);
    in_rs = v.rs; in_rt = v.rt; in_imm = v.imm; in_sext = v.sext;
    in_valid = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back(v);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", sb.size(), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   w;
    int   hs0;
    logic [31:0] byp_a;

    tbl[0] = '{5'd3,  5'd4,  16'h8000, 1'b1, 32'h11,        32'h22,        32'hFFFF8000};
    tbl[1] = '{5'd3,  5'd4,  16'h8000, 1'b0, 32'h11,        32'h22,        32'h00008000};
    tbl[2] = '{5'd0,  5'd3,  16'h7FFF, 1'b1, 32'h0,         32'h11,        32'h00007FFF};
    tbl[3] = '{5'd5,  5'd0,  16'h1234, 1'b0, 32'hA0000005,  32'h0,         32'h00001234};
    tbl[4] = '{5'd31, 5'd31, 16'hFFFF, 1'b1, 32'hA000001F,  32'hA000001F,  32'hFFFFFFFF};
    tbl[5] = '{5'd0,  5'd0,  16'h0001, 1'b1, 32'h0,         32'h0,         32'h00000001};

    reset = 1'b1; in_valid = 1'b0; in_rs = 5'd0; in_rt = 5'd0; in_imm = 16'd0;
    in_sext = 1'b0; out_ready = 1'b1; wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;

    // Load the register file while the stage is in reset (RF[0] gets 0x55).
    wb_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wb_reg  = 5'(i);
      wb_data = (i == 0) ? 32'h55 : (i == 3) ? 32'h11 : (i == 4) ? 32'h22
                : (32'hA0000000 | 32'(i));
      @(posedge clock); #1;
    end
    wb_en = 1'b0;

    @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_A", A, 32'd0);
    check("rst_Imm", Imm, 32'd0);
    check("rst_Read1", {27'd0, Read1}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;

    // Back-to-back stream from the table, ALU always ready.
    hs0 = hs_count; have_last = 1'b0; gap_chk = 1'b1;
    for (int i = 0; i < 6; i++) send(tbl[i], w);
    drain();
    gap_chk = 1'b0;
    check("stream_pulses", hs_count - hs0, 32'd6);

    // Latency and stall: ALU holds off for 5 cycles in VALID.
    out_ready = 1'b0;
    send(tbl[0], w);
    @(negedge clock);
    check("fetch_out_valid", {31'd0, out_valid}, 32'd0);
    check("fetch_Read1", {27'd0, Read1}, 32'd3);
    check("fetch_Read2", {27'd0, Read2}, 32'd4);
    @(posedge clock); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_A", A, 32'h11);
      check("stall_B", B, 32'h22);
      check("stall_Imm", Imm, 32'hFFFF8000);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    send(tbl[1], w);
    check("release_accept_wait", w, 32'd0);
    @(negedge clock);
    check("b2b_out_valid_gap", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset held for 2 cycles in the middle of a FETCH drops the request.
    send(tbl[3], w);
    reset = 1'b1;
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_A", A, 32'd0);
    check("mid_rst_B", B, 32'd0);
    check("mid_rst_Imm", Imm, 32'd0);
    check("mid_rst_Read1", {27'd0, Read1}, 32'd0);
    check("mid_rst_Read2", {27'd0, Read2}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;

    // Write-back on the FETCH edge of rs=3.
`ifdef OPF_BYPASS_EN
    byp_a = 32'hABCD;
`else
    byp_a = 32'h11;
`endif
    v = '{5'd3, 5'd4, 16'h0000, 1'b0, byp_a, 32'h22, 32'h0};
    send(v, w);
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'hABCD;
    @(posedge clock); #1;
    wb_en = 1'b0;
    drain();

    // Write-back to register 0 during FETCH: zero forcing wins.
    v = '{5'd0, 5'd3, 16'h0000, 1'b0, 32'h0, 32'hABCD, 32'h0};
    send(v, w);
    wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'h77;
    @(posedge clock); #1;
    wb_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
